// File: rtl/bus_txn_arbiter_if.sv
// Requester, bus-issue, bus-response and completion signals of the transaction arbiter.
// Pure wiring: no latency of its own.
// Backpressure: bus_ready stalls an issued request; requesters wait for a req_ready pulse.
interface bus_txn_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [2*NUM_REQ-1:0]  req_cmd;
    logic [8*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  bus_valid;
    logic [1:0]            bus_cmd;
    logic [7:0]            bus_addr;
    logic [31:0]           bus_data;
    logic [3:0]            bus_id;
    logic                  bus_ready;

    logic                  resp_valid;
    logic [3:0]            resp_id;
    logic [31:0]           resp_data;
    logic                  resp_error;

    logic [NUM_REQ-1:0]    done_valid;
    logic [31:0]           done_data;
    logic                  done_error;

    modport master (
        input  req_valid, req_cmd, req_addr, req_data,
        input  bus_ready,
        input  resp_valid, resp_id, resp_data, resp_error,
        output req_ready,
        output bus_valid, bus_cmd, bus_addr, bus_data, bus_id,
        output done_valid, done_data, done_error
    );

    modport slave (
        output req_valid, req_cmd, req_addr, req_data,
        output bus_ready,
        output resp_valid, resp_id, resp_data, resp_error,
        input  req_ready,
        input  bus_valid, bus_cmd, bus_addr, bus_data, bus_id,
        input  done_valid, done_data, done_error
    );
endinterface

// File: rtl/bus_txn_arbiter.sv
// Round-robin arbiter issuing one tagged bus transaction at a time, with response timeout.
// Latency: grant in the IDLE cycle, bus_valid the next cycle, completion pulse on matching response.
// Backpressure: request held on the bus until bus_ready; no new grant until the transaction completes.
module bus_txn_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              err_clear,
    output logic [1:0]        state,
    bus_txn_arbiter_if.master bif
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [1:0] CMD_WRITE   = 2'd1;
    localparam logic [1:0] CMD_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
    } hdr_t;

    state_e        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [3:0]    tag_q, tag_d;
    logic [3:0]    id_q, id_d;
    logic [7:0]    cnt_q, cnt_d;
    hdr_t          hdr_q, hdr_d;

    logic               gnt_found;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      cand;
    logic               resp_match;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [NUM_REQ-1:0] done_valid_c;
    logic [31:0]        done_data_c;
    logic               done_error_c;
    logic               bus_valid_c;

    // First requesting index strictly after the last grant, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!gnt_found && bif.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        tag_d        = tag_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        req_ready_c  = '0;
        done_valid_c = '0;
        done_data_c  = '0;
        done_error_c = 1'b0;
        bus_valid_c  = 1'b0;
        resp_match   = bif.resp_valid && (bif.resp_id == id_q);

        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    req_ready_c[gnt_idx] = 1'b1;
                    rr_ptr_d   = gnt_idx;
                    gnt_d      = gnt_idx;
                    id_d       = tag_q;
                    tag_d      = tag_q + 4'd1;
                    hdr_d.cmd  = bif.req_cmd[2*gnt_idx +: 2];
                    hdr_d.addr = bif.req_addr[8*gnt_idx +: 8];
                    hdr_d.data = bif.req_data[32*gnt_idx +: 32];
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (hdr_q.cmd == CMD_ILLEGAL) begin
                    done_valid_c[gnt_q] = 1'b1;
                    done_error_c        = 1'b1;
                    state_d             = ST_ERROR;
                end else begin
                    bus_valid_c = 1'b1;
                    if (bif.bus_ready) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A matching response takes priority over an expiring timeout.
                if (resp_match) begin
                    done_valid_c[gnt_q] = 1'b1;
                    done_data_c         = bif.resp_data;
                    done_error_c        = bif.resp_error;
                    state_d             = bif.resp_error ? ST_ERROR : ST_IDLE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    done_valid_c[gnt_q] = 1'b1;
                    done_error_c        = 1'b1;
                    state_d             = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ERROR: begin
                if (err_clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= PW'(NUM_REQ - 1);
            gnt_q    <= '0;
            tag_q    <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            hdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            tag_q    <= tag_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
        end
    end

    // Outputs are forced quiet while reset is asserted, even before the first reset edge.
    assign bif.req_ready  = rst ? '0 : req_ready_c;
    assign bif.done_valid = rst ? '0 : done_valid_c;
    assign bif.done_data  = rst ? '0 : done_data_c;
    assign bif.done_error = rst ? 1'b0 : done_error_c;
    assign bif.bus_valid  = rst ? 1'b0 : bus_valid_c;
    assign bif.bus_cmd    = rst ? '0 : hdr_q.cmd;
    assign bif.bus_addr   = rst ? '0 : hdr_q.addr;
    assign bif.bus_data   = (rst || hdr_q.cmd != CMD_WRITE) ? '0 : hdr_q.data;
    assign bif.bus_id     = rst ? '0 : id_q;
    assign state          = state_q;
endmodule

// File: tb/tb_bus_txn_arbiter.sv
// Directed bench for bus_txn_arbiter: round-robin order, bus stall, timeout, tag matching, errors, reset.
module tb_bus_txn_arbiter;
    logic       clk;
    logic       rst;
    logic       err_clear;
    logic [1:0] state;
    int         checks;
    int         errors;

    bus_txn_arbiter_if #(.NUM_REQ(4)) bif ();

    bus_txn_arbiter #(.NUM_REQ(4), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .err_clear (err_clear),
        .state     (state),
        .bif       (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] cmd, input logic [7:0] addr,
                           input logic [31:0] data);
        bif.req_cmd[2*r +: 2]   = cmd;
        bif.req_addr[8*r +: 8]  = addr;
        bif.req_data[32*r +: 32] = data;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        err_clear      = 1'b0;
        bif.req_valid  = 4'b0001;
        bif.req_cmd    = '0;
        bif.req_addr   = '0;
        bif.req_data   = '0;
        bif.bus_ready  = 1'b0;
        bif.resp_valid = 1'b0;
        bif.resp_id    = '0;
        bif.resp_data  = '0;
        bif.resp_error = 1'b0;

        // Reset state, with a request pending that must not be granted.
        tick(); tick(); settle();
        chk("rst_state",      64'(state),          64'(0));
        chk("rst_req_ready",  64'(bif.req_ready),  64'(0));
        chk("rst_bus_valid",  64'(bif.bus_valid),  64'(0));
        chk("rst_bus_id",     64'(bif.bus_id),     64'(0));
        chk("rst_done_valid", 64'(bif.done_valid), 64'(0));
        bif.req_valid = '0;
        rst = 1'b0;

        // Single WRITE from requester 0, response three WAIT cycles later.
        set_req(0, 2'd1, 8'hFF, 32'hDEADBEEF);
        bif.req_valid = 4'b0001;
        bif.bus_ready = 1'b1;
        settle();
        chk("w_req_ready", 64'(bif.req_ready), 64'(4'b0001));
        tick();
        bif.req_valid = '0;
        settle();
        chk("w_state_active", 64'(state),         64'(1));
        chk("w_bus_valid",    64'(bif.bus_valid), 64'(1));
        chk("w_bus_id",       64'(bif.bus_id),    64'(0));
        chk("w_bus_cmd",      64'(bif.bus_cmd),   64'(1));
        chk("w_bus_addr",     64'(bif.bus_addr),  64'(8'hFF));
        chk("w_bus_data",     64'(bif.bus_data),  64'(32'hDEADBEEF));
        tick(); settle();
        chk("w_state_wait",   64'(state),         64'(2));
        chk("w_wait_novalid", 64'(bif.bus_valid), 64'(0));
        tick(); tick();
        bif.resp_valid = 1'b1;
        bif.resp_id    = 4'd0;
        bif.resp_data  = 32'h12345678;
        settle();
        chk("w_done_valid", 64'(bif.done_valid), 64'(4'b0001));
        chk("w_done_data",  64'(bif.done_data),  64'(32'h12345678));
        chk("w_done_error", 64'(bif.done_error), 64'(0));
        tick();
        bif.resp_valid = 1'b0;
        settle();
        chk("w_state_idle", 64'(state), 64'(0));

        // Fresh reset, then all four requesting: grants 0,1,2,3,0,1,2,3 with ids 0..7.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bif.req_cmd   = '0;
        bif.req_valid = 4'b1111;
        bif.bus_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("rr_grant", 64'(bif.req_ready), 64'(4'b0001 << (k % 4)));
            tick(); settle();
            chk("rr_busy_no_ready", 64'(bif.req_ready), 64'(0));
            chk("rr_bus_id",        64'(bif.bus_id),    64'(k));
            tick();
            bif.resp_valid = 1'b1;
            bif.resp_id    = 4'(k);
            bif.resp_data  = 32'(k);
            settle();
            chk("rr_done", 64'(bif.done_valid), 64'(4'b0001 << (k % 4)));
            tick();
            bif.resp_valid = 1'b0;
        end

        // Requester 2 READ stalled by bus_ready for five cycles, then timeout.
        bif.req_valid = 4'b0100;
        set_req(2, 2'd0, 8'h5A, 32'hCAFEF00D);
        bif.bus_ready = 1'b0;
        settle();
        chk("st_req_ready", 64'(bif.req_ready), 64'(4'b0100));
        tick();
        bif.req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("st_state",     64'(state),         64'(1));
            chk("st_bus_valid", 64'(bif.bus_valid), 64'(1));
            chk("st_bus_addr",  64'(bif.bus_addr),  64'(8'h5A));
            chk("st_bus_data",  64'(bif.bus_data),  64'(0));
            chk("st_bus_id",    64'(bif.bus_id),    64'(8));
            tick();
        end
        bif.bus_ready = 1'b1;
        tick();
        bif.bus_ready = 1'b0;
        settle();
        chk("st_state_wait", 64'(state),         64'(2));
        chk("st_wait_novld", 64'(bif.bus_valid), 64'(0));
        for (int c = 0; c < 4; c++) begin
            chk("to_quiet", 64'(bif.done_valid), 64'(0));
            tick(); settle();
        end
        chk("to_done_valid", 64'(bif.done_valid), 64'(4'b0100));
        chk("to_done_error", 64'(bif.done_error), 64'(1));
        chk("to_done_data",  64'(bif.done_data),  64'(0));
        tick(); settle();
        chk("to_state_err", 64'(state),         64'(3));
        chk("to_err_novld", 64'(bif.bus_valid), 64'(0));
        bif.req_valid = 4'b0001;
        settle();
        chk("err_no_grant", 64'(bif.req_ready), 64'(0));
        tick(); settle();
        chk("err_holds", 64'(state), 64'(3));
        bif.req_valid = '0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        settle();
        chk("err_clear_idle", 64'(state), 64'(0));

        // Response arriving in the same cycle the timeout expires: the response is reported.
        bif.req_valid = 4'b0010;
        set_req(1, 2'd1, 8'h01, 32'h11111111);
        bif.bus_ready = 1'b1;
        settle();
        chk("rt_req_ready", 64'(bif.req_ready), 64'(4'b0010));
        tick();
        bif.req_valid = '0;
        settle();
        chk("rt_bus_id",   64'(bif.bus_id),   64'(9));
        chk("rt_bus_data", 64'(bif.bus_data), 64'(32'h11111111));
        tick();
        for (int c = 0; c < 4; c++) tick();
        bif.resp_valid = 1'b1;
        bif.resp_id    = 4'd9;
        bif.resp_error = 1'b1;
        bif.resp_data  = 32'hABCD;
        settle();
        chk("rt_done_valid", 64'(bif.done_valid), 64'(4'b0010));
        chk("rt_done_error", 64'(bif.done_error), 64'(1));
        chk("rt_done_data",  64'(bif.done_data),  64'(32'hABCD));
        tick();
        bif.resp_valid = 1'b0;
        bif.resp_error = 1'b0;
        settle();
        chk("rt_state_err", 64'(state), 64'(3));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Requester 3 ERASE: mismatched response ignored, matching one completes.
        bif.req_valid = 4'b1000;
        set_req(3, 2'd2, 8'h33, 32'hFFFFFFFF);
        bif.bus_ready = 1'b1;
        settle();
        chk("id_req_ready", 64'(bif.req_ready), 64'(4'b1000));
        tick();
        bif.req_valid = '0;
        settle();
        chk("id_bus_cmd",  64'(bif.bus_cmd),  64'(2));
        chk("id_bus_data", 64'(bif.bus_data), 64'(0));
        chk("id_bus_id",   64'(bif.bus_id),   64'(10));
        tick();
        bif.resp_valid = 1'b1;
        bif.resp_id    = 4'd5;
        bif.resp_data  = 32'h55;
        settle();
        chk("id_wrong_ignored", 64'(bif.done_valid), 64'(0));
        tick(); settle();
        chk("id_still_wait", 64'(state), 64'(2));
        bif.resp_id   = 4'd10;
        bif.resp_data = 32'h77;
        settle();
        chk("id_done_valid", 64'(bif.done_valid), 64'(4'b1000));
        chk("id_done_data",  64'(bif.done_data),  64'(32'h77));
        chk("id_done_error", 64'(bif.done_error), 64'(0));
        tick();
        bif.resp_valid = 1'b0;
        settle();
        chk("id_state_idle", 64'(state), 64'(0));

        // Illegal command on requester 1: never issued, error completion.
        bif.req_valid = 4'b0010;
        set_req(1, 2'd3, 8'h44, 32'h12345678);
        settle();
        chk("il_req_ready", 64'(bif.req_ready), 64'(4'b0010));
        tick();
        bif.req_valid = '0;
        settle();
        chk("il_bus_valid",  64'(bif.bus_valid),  64'(0));
        chk("il_done_valid", 64'(bif.done_valid), 64'(4'b0010));
        chk("il_done_error", 64'(bif.done_error), 64'(1));
        chk("il_done_data",  64'(bif.done_data),  64'(0));
        tick(); settle();
        chk("il_state_err", 64'(state), 64'(3));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Reset during WAIT abandons the transaction; its late response is ignored.
        bif.req_valid = 4'b0001;
        set_req(0, 2'd0, 8'h10, 32'h0);
        bif.bus_ready = 1'b1;
        settle();
        chk("rw_req_ready", 64'(bif.req_ready), 64'(4'b0001));
        tick();
        bif.req_valid = '0;
        settle();
        chk("rw_bus_id", 64'(bif.bus_id), 64'(12));
        tick(); settle();
        chk("rw_state_wait", 64'(state), 64'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rw_state_idle", 64'(state),          64'(0));
        chk("rw_no_done",    64'(bif.done_valid), 64'(0));
        chk("rw_bus_id_clr", 64'(bif.bus_id),     64'(0));
        bif.resp_valid = 1'b1;
        bif.resp_id    = 4'd12;
        settle();
        chk("rw_late_resp", 64'(bif.done_valid), 64'(0));
        tick();
        bif.resp_valid = 1'b0;
        bif.req_valid  = 4'b0011;
        settle();
        chk("rw_rr_reset", 64'(bif.req_ready), 64'(4'b0001));
        tick();
        bif.req_valid = '0;
        settle();
        chk("rw_tag_reset", 64'(bif.bus_id), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
